aes_job_scheduler: RTL and testbench

//  Shares one AES_top core between two requesters (e.g. host port, DMA port).

---
 rtl/aes_job_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_aes_job_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one AES core between two requesters.
// Round-robin grant, registered core key/plain text, fixed-latency timing,
// last-key cache that skips the key-expansion wait on an unchanged key.
// Optional decrypt self-check enabled by defining AES_SCHED_CHECK_EN.
module aes_job_scheduler #(
    parameter int unsigned CORE_LAT = 11,
    parameter int unsigned KEY_LAT  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_data,
    output logic [127:0] core_key,
    output logic [127:0] core_plain_text,
    input  logic [127:0] core_cipher_text,
    input  logic [127:0] core_decrypted,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_id,
    output logic         out_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] CORE_LAT_M1 = 8'(CORE_LAT - 1);
    localparam logic [7:0] KEY_LAT_M1  = 8'(KEY_LAT - 1);

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] core_key_q, core_key_d;
    logic [127:0] core_pt_q, core_pt_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         out_id_q, out_id_d;
    logic         rr_ptr_q, rr_ptr_d;
    logic         key_vld_q, key_vld_d;
    logic         busy_q, busy_d;

    logic         any_req_s;
    logic         grant_id_s;
    logic         idle_s;
    logic [127:0] sel_key_s;
    logic [127:0] sel_data_s;
    logic         key_hit_s;

`ifdef AES_SCHED_CHECK_EN
    logic         out_err_q, out_err_d;
`else
    logic         unused_decrypted_s;
`endif

    // Arbitration: lone requester wins, contention resolved by rr_ptr.
    always_comb begin
        any_req_s = req0_valid | req1_valid;
        idle_s    = (state_q == ST_IDLE);
        if (req0_valid && req1_valid) begin
            grant_id_s = rr_ptr_q;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        if (grant_id_s) begin
            sel_key_s  = req1_key;
            sel_data_s = req1_data;
        end else begin
            sel_key_s  = req0_key;
            sel_data_s = req0_data;
        end
        key_hit_s = key_vld_q && (sel_key_s == core_key_q);
    end

    assign req0_ready = idle_s & req0_valid & ~grant_id_s;
    assign req1_ready = idle_s & req1_valid &  grant_id_s;

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_key_d  = core_key_q;
        core_pt_d   = core_pt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        key_vld_d   = key_vld_q;
`ifdef AES_SCHED_CHECK_EN
        out_err_d   = out_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    core_key_d = sel_key_s;
                    core_pt_d  = sel_data_s;
                    out_id_d   = grant_id_s;
                    rr_ptr_d   = ~grant_id_s;
                    if (key_hit_s) begin
                        state_d = ST_RUN;
                        cnt_d   = CORE_LAT_M1;
                    end else begin
                        state_d   = ST_KEYEXP;
                        cnt_d     = KEY_LAT_M1;
                        key_vld_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                    cnt_d   = CORE_LAT_M1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                if (cnt_q == 8'd0) begin
                    out_data_d  = core_cipher_text;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
`ifdef AES_SCHED_CHECK_EN
                    out_err_d   = (core_decrypted != core_pt_q);
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
`ifdef AES_SCHED_CHECK_EN
                    out_err_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any job and the key cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            core_key_q  <= 128'd0;
            core_pt_q   <= 128'd0;
            out_data_q  <= 128'd0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            rr_ptr_q    <= 1'b0;
            key_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            core_key_q  <= core_key_d;
            core_pt_q   <= core_pt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
            key_vld_q   <= key_vld_d;
            busy_q      <= busy_d;
        end
    end

`ifdef AES_SCHED_CHECK_EN
    // Decrypt-mismatch flag register, travels with out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end
    assign out_err = out_err_q;
`else
    assign unused_decrypted_s = ^core_decrypted;
    assign out_err            = 1'b0;
`endif

    assign core_key        = core_key_q;
    assign core_plain_text = core_pt_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_id          = out_id_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Testbench for aes_job_scheduler: transaction-level reference model
// (job queues, accept timestamps, key cache) plus directed scenarios.
module tb_aes_job_scheduler;

    localparam int CORE_LAT = 11;
    localparam int KEY_LAT  = 10;
    localparam logic [127:0] KVEC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PVEC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CVEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_key = 128'd0, req0_data = 128'd0;
    logic [127:0] req1_key = 128'd0, req1_data = 128'd0;
    logic [127:0] core_key, core_plain_text, core_cipher_text, core_decrypted;
    logic         out_valid, out_id, out_err, busy;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         corrupt = 1'b0;

    aes_job_scheduler #(.CORE_LAT(CORE_LAT), .KEY_LAT(KEY_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_data(req1_data),
        .core_key(core_key), .core_plain_text(core_plain_text),
        .core_cipher_text(core_cipher_text), .core_decrypted(core_decrypted),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in AES core: real vector for the known key/plain pair, else a keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == KVEC && p == PVEC) return CVEC;
        return {k[63:0] ^ p[127:64], k[127:64] + p[63:0]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always_comb begin
        core_cipher_text = core_fn(core_key, core_plain_text);
        core_decrypted   = corrupt ? (core_plain_text ^ 128'd1) : core_plain_text;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model state
    logic [255:0] q0[$];
    logic [255:0] q1[$];
    bit           served[$];
    bit           m_busy = 1'b0, m_kv = 1'b0, m_rr = 1'b0, m_id = 1'b0, m_err = 1'b0;
    int           m_acc = 0, m_lat = 0, edge_cnt = 0;
    logic [127:0] m_data = 128'd0, m_key_last = 128'd0, m_ck = 128'd0, m_cp = 128'd0;
    int           ready_pct = 100, valid_pct = 100;
    bit           hold_valid = 1'b1;
    bit           prev_ov = 1'b0;
    int           obs_lat = 0;
    logic [127:0] obs_data = 128'd0;
    logic         obs_id = 1'b0, obs_err = 1'b0;

    task automatic step();
        bit v0, v1, g, acc, ov_pre, ov;
        @(negedge clk);
        v0 = (q0.size() > 0) && (hold_valid || ($urandom_range(0, 99) < valid_pct));
        v1 = (q1.size() > 0) && (hold_valid || ($urandom_range(0, 99) < valid_pct));
        req0_valid = v0;
        req1_valid = v1;
        if (v0) {req0_key, req0_data} = q0[0];
        else    {req0_key, req0_data} = {rnd128(), rnd128()};
        if (v1) {req1_key, req1_data} = q1[0];
        else    {req1_key, req1_data} = {rnd128(), rnd128()};
        out_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        g   = (v0 && v1) ? m_rr : v1;
        acc = !m_busy && (v0 || v1);
        chk("req0_ready", 128'(req0_ready), 128'(acc && !g));
        chk("req1_ready", 128'(req1_ready), 128'(acc && g));
        ov_pre = m_busy && (edge_cnt - m_acc >= m_lat);
        @(posedge clk);
        edge_cnt++;
        if (ov_pre && out_ready) begin
            m_busy = 1'b0;
            served.push_back(m_id);
        end else if (acc) begin
            logic [255:0] j;
            if (g) j = q1.pop_front();
            else   j = q0.pop_front();
            m_lat = (m_kv && j[255:128] == m_key_last) ? CORE_LAT : KEY_LAT + CORE_LAT;
            m_key_last = j[255:128];
            m_kv   = 1'b1;
            m_rr   = ~g;
            m_id   = g;
            m_acc  = edge_cnt;
            m_busy = 1'b1;
            m_ck   = j[255:128];
            m_cp   = j[127:0];
            m_data = core_fn(j[255:128], j[127:0]);
`ifdef AES_SCHED_CHECK_EN
            m_err  = corrupt;
`else
            m_err  = 1'b0;
`endif
        end
        #1;
        ov = m_busy && (edge_cnt - m_acc >= m_lat);
        chk("out_valid", 128'(out_valid), 128'(ov));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("core_key", core_key, m_ck);
        chk("core_plain_text", core_plain_text, m_cp);
        chk("out_err", 128'(out_err), 128'(ov ? m_err : 1'b0));
        if (ov) begin
            chk("out_data", out_data, m_data);
            chk("out_id", 128'(out_id), 128'(m_id));
        end
        if (out_valid && !prev_ov) begin
            obs_lat  = edge_cnt - m_acc;
            obs_data = out_data;
            obs_id   = out_id;
            obs_err  = out_err;
        end
        prev_ov = out_valid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_kv = 1'b0; m_rr = 1'b0;
        m_ck = 128'd0; m_cp = 128'd0;
        prev_ov = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((m_busy || q0.size() > 0 || q1.size() > 0) && i < budget) begin
            step();
            i++;
        end
        if (m_busy || q0.size() > 0 || q1.size() > 0) chk("drain timeout", 128'd1, 128'd0);
    endtask

    logic [127:0] key_pool[3];

    initial begin
        do_reset();
        chk("reset core_key", core_key, 128'd0);
        chk("reset core_plain_text", core_plain_text, 128'd0);
        chk("reset out_data", out_data, 128'd0);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset out_id", 128'(out_id), 128'd0);
        chk("reset out_err", 128'(out_err), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);

        // known vector, key miss, then key hit via the other requester
        q0.push_back({KVEC, PVEC});
        drain(200);
        chk("T2 latency", 128'(obs_lat), 128'd21);
        chk("T2 out_data", obs_data, CVEC);
        chk("T2 out_id", 128'(obs_id), 128'd0);
        q1.push_back({KVEC, PVEC});
        drain(200);
        chk("T3 latency", 128'(obs_lat), 128'd11);
        chk("T3 out_data", obs_data, CVEC);
        chk("T3 out_id", 128'(obs_id), 128'd1);

        // contention with both requesters held valid
        served.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back({KVEC, rnd128()});
            q1.push_back({KVEC, rnd128()});
        end
        drain(400);
        chk("T4 count", 128'(served.size()), 128'd4);
        for (int i = 0; i < 4 && i < served.size(); i++)
            chk($sformatf("T4 order %0d", i), 128'(served[i]), 128'(i % 2));

        // consumer stall
        ready_pct = 0;
        q0.push_back({rnd128(), rnd128()});
        q1.push_back({rnd128(), rnd128()});
        for (int i = 0; i < 45; i++) step();
        chk("T5 held valid", 128'(out_valid), 128'd1);
        ready_pct = 100;
        drain(400);

        // reset while running; next job must pay key expansion again
        q0.push_back({KVEC, rnd128()});
        for (int i = 0; i < 15; i++) step();
        chk("T1 busy before reset", 128'(busy), 128'd1);
        do_reset();
        q0.push_back({KVEC, PVEC});
        drain(200);
        chk("T1 post-reset latency", 128'(obs_lat), 128'd21);

        // decrypt self-check
        corrupt = 1'b1;
        q1.push_back({KVEC, PVEC});
        drain(200);
`ifdef AES_SCHED_CHECK_EN
        chk("T6 err corrupt", 128'(obs_err), 128'd1);
`else
        chk("T6 err tied", 128'(obs_err), 128'd0);
`endif
        corrupt = 1'b0;
        q1.push_back({KVEC, PVEC});
        drain(200);
        chk("T6 err clean", 128'(obs_err), 128'd0);

        // randomized traffic over a small key pool to mix hits and misses
        key_pool[0] = KVEC;
        key_pool[1] = rnd128();
        key_pool[2] = rnd128();
        hold_valid = 1'b0;
        valid_pct  = 60;
        ready_pct  = 50;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 8) begin
                if ($urandom_range(0, 1) == 0) q0.push_back({key_pool[$urandom_range(0, 2)], rnd128()});
                else                           q1.push_back({key_pool[$urandom_range(0, 2)], rnd128()});
            end
            step();
        end
        drain(5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
